// File: rtl/font_fetch_pkg.sv
// Shared definitions for the font glyph fetcher.
//   GLYPH_COLS / CHAR_W / ROM_AW / COL_W : glyph and font ROM geometry
//   LAST_COL    : index of the final column of a glyph
//   fsm_state_t : fetch sequencer states
//   col_entry_t : one buffered column (ROM byte plus its tags)
package font_fetch_pkg;

  localparam int unsigned GLYPH_COLS = 8;
  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned ROM_AW     = 11;
  localparam int unsigned COL_W      = 3;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(GLYPH_COLS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic [CHAR_W-1:0] data;
    logic [COL_W-1:0]  col;
    logic              owner;
    logic              inv;
  } col_entry_t;

endpackage

// File: rtl/font_col_fifo.sv
// Small synchronous FIFO buffering glyph columns between the ROM and the
// column consumer. Push and pop may occur in the same cycle, including when
// full (count unchanged). Head entry is presented combinationally.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push, i_entry : write strobe and entry
//   i_pop        : remove head entry (caller guarantees non-empty)
//   o_head       : current head entry (zero after reset)
//   o_count      : number of stored entries
module font_col_fifo
  import font_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  col_entry_t    i_entry,
  input  logic          i_pop,
  output col_entry_t    o_head,
  output logic [CW-1:0] o_count
);

  col_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointer wrap handles depths that are not a power of two.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= f_next(r_wr_ptr);
      end
      if (i_pop) r_rd_ptr <= f_next(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/font_glyph_fetcher.sv
// Arbitrates two glyph requesters (port 0 display scan-out, port 1 CPU
// console) onto the 8x8 font ROM, issues the 8 column reads of each granted
// character and streams the column bytes out with valid/ready backpressure.
// Optional build macro: FONT_FETCH_INVERT_EN adds req_inv; an inverted
// glyph is emitted as ~rom_data.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   req_valid   : per-port request;  req_char : port i char on [8i+7:8i]
//   req_ready   : one-hot grant pulse
//   req_inv     : per-port reverse-video flag (FONT_FETCH_INVERT_EN only)
//   rom_addr    : {char, col};  rom_data : ROM byte, one cycle later
//   col_valid/col_ready : output handshake
//   col_data, col_idx, col_last, col_owner : column byte and its tags
module font_glyph_fetcher
  import font_fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned NREQ       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [CHAR_W*NREQ-1:0] req_char,
`ifdef FONT_FETCH_INVERT_EN
  input  logic [NREQ-1:0]        req_inv,
`endif
  output logic [NREQ-1:0]        req_ready,
  output logic [ROM_AW-1:0]      rom_addr,
  input  logic [CHAR_W-1:0]      rom_data,
  output logic                   col_valid,
  input  logic                   col_ready,
  output logic [CHAR_W-1:0]      col_data,
  output logic [COL_W-1:0]       col_idx,
  output logic                   col_last,
  output logic                   col_owner
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fsm_state_t        r_state, w_state_nxt;
  logic [ROM_AW-1:0] r_addr;
  logic              r_owner, r_inv, r_rr;
  logic              r_inflight;
  logic [COL_W-1:0]  r_tag_col;
  logic              r_tag_owner, r_tag_inv;

  logic              w_grant, w_gnt, w_gnt_inv, w_issue, w_pop, w_credit;
  logic [CW-1:0]     w_count;
  logic [CW:0]       w_occupancy;
  col_entry_t        w_push_entry, w_head;

`ifdef FONT_FETCH_INVERT_EN
  assign w_gnt_inv = req_inv[w_gnt];
`else
  assign w_gnt_inv = 1'b0;
`endif

  // Credit: buffered + returning read - column leaving this cycle must leave
  // room for the read issued now, so the FIFO can never overflow.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight}
                     - {{CW{1'b0}}, w_pop};
  assign w_credit    = w_occupancy < (CW + 1)'(FIFO_DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gnt       = 1'b0;
    w_issue     = 1'b0;
    req_ready   = '0;
    case (r_state)
      IDLE: begin
        if (!reset && (|req_valid)) begin
          w_grant            = 1'b1;
          // r_rr holds the port that wins the next tie.
          w_gnt              = (&req_valid) ? r_rr : req_valid[1];
          req_ready[w_gnt]   = 1'b1;
          w_state_nxt        = FETCH;
        end
      end
      FETCH: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_addr[COL_W-1:0] == LAST_COL) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_owner     <= 1'b0;
      r_inv       <= 1'b0;
      r_rr        <= 1'b0;
      r_inflight  <= 1'b0;
      r_tag_col   <= '0;
      r_tag_owner <= 1'b0;
      r_tag_inv   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_grant) begin
        r_addr  <= {(w_gnt ? req_char[CHAR_W +: CHAR_W] : req_char[0 +: CHAR_W]),
                    {COL_W{1'b0}}};
        r_owner <= w_gnt;
        r_inv   <= w_gnt_inv;
        r_rr    <= ~w_gnt;
      end
      if (w_issue) begin
        // Tags ride alongside the read so the returning byte is labelled
        // even after the next glyph has been granted.
        r_tag_col   <= r_addr[COL_W-1:0];
        r_tag_owner <= r_owner;
        r_tag_inv   <= r_inv;
        if (r_addr[COL_W-1:0] != LAST_COL)
          r_addr[COL_W-1:0] <= r_addr[COL_W-1:0] + 1'b1;
      end
    end
  end

  assign w_push_entry = '{data: rom_data, col: r_tag_col,
                          owner: r_tag_owner, inv: r_tag_inv};

  font_col_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (r_inflight),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign rom_addr  = r_addr;
  assign col_valid = (w_count != '0);
  assign w_pop     = col_valid & col_ready;
  assign col_data  = w_head.data ^ {CHAR_W{w_head.inv}};
  assign col_idx   = w_head.col;
  assign col_last  = (w_head.col == LAST_COL);
  assign col_owner = w_head.owner;

endmodule

// File: tb/tb_font_glyph_fetcher.sv
module tb_font_glyph_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_char = '0;
  logic [1:0]  req_inv = '0;
  logic [1:0]  req_ready;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        col_valid, col_ready = 1'b1;
  logic [7:0]  col_data;
  logic [2:0]  col_idx;
  logic        col_last, col_owner;

  font_glyph_fetcher #(.FIFO_DEPTH(2), .NREQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_char  (req_char),
`ifdef FONT_FETCH_INVERT_EN
    .req_inv   (req_inv),
`endif
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_data  (col_data),
    .col_idx   (col_idx),
    .col_last  (col_last),
    .col_owner (col_owner)
  );

  always #5 clk = ~clk;

  // Font ROM model: random contents, one-cycle synchronous read.
  logic [7:0] rom_mem [2048];
  initial for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each grant expands into 8 expected columns.
  typedef struct {
    logic [7:0] data;
    int         col;
    logic       owner;
  } exp_t;

  exp_t q[$];
  bit   grant_log[$];
  bit   m_rr = 1'b0;
  int   cyc = 0;
  int   n_pop = 0;
  bit   bubble_en = 1'b0;
  bit   have_last = 1'b0;
  int   last_cyc = 0;
  int   n_bubble = 0;
  bit   p_stall = 1'b0;
  logic [7:0] p_data;
  logic [2:0] p_idx;
  logic       p_owner;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      m_rr      = 1'b0;
      p_stall   = 1'b0;
      have_last = 1'b0;
      n_pop     = 0;
    end else begin
      if (p_stall) begin
        check_eq("stall_valid", col_valid, 1);
        check_eq("stall_data", col_data, p_data);
        check_eq("stall_idx", col_idx, p_idx);
        check_eq("stall_owner", col_owner, p_owner);
      end
      check_eq("fifo_bound", dut.u_fifo.o_count <= 2, 1);
      if (req_ready != 2'b00) begin
        bit g, eg, inv_g;
        logic [7:0] ch;
        g = req_ready[1];
        check_eq("grant_onehot", $countones(req_ready), 1);
        check_eq("grant_valid", req_valid[g], 1);
        eg = (&req_valid) ? m_rr : req_valid[1];
        check_eq("grant_port", g, eg);
        m_rr = ~g;
        grant_log.push_back(g);
        ch = g ? req_char[15:8] : req_char[7:0];
`ifdef FONT_FETCH_INVERT_EN
        inv_g = req_inv[g];
`else
        inv_g = 1'b0;
`endif
        for (int c = 0; c < 8; c++) begin
          exp_t e;
          logic [2:0] cc;
          cc = 3'(c);
          e.data  = rom_mem[{ch, cc}] ^ {8{inv_g}};
          e.col   = c;
          e.owner = g;
          q.push_back(e);
        end
      end
      if (col_valid && col_ready) begin
        n_pop++;
        if (q.size() == 0) begin
          check_eq("spurious_col", col_valid, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_eq("col_data", col_data, e.data);
          check_eq("col_idx", col_idx, e.col);
          check_eq("col_last", col_last, e.col == 7);
          check_eq("col_owner", col_owner, e.owner);
          if (bubble_en) begin
            if (have_last && e.col == 0) begin
              check_eq("bubble_gap", cyc - last_cyc, 2);
              n_bubble++;
              have_last = 1'b0;
            end
            if (e.col == 7) begin
              have_last = 1'b1;
              last_cyc  = cyc;
            end
          end
        end
      end
      p_stall = col_valid && !col_ready;
      p_data  = col_data;
      p_idx   = col_idx;
      p_owner = col_owner;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0; col_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) return;
    end
    check_eq("grant_timeout", req_ready, 1);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    req_valid = '0; col_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !col_valid && dut.r_state == 1'b0) break;
    end
    check_eq("drain_queue", q.size(), 0);
    check_eq("drain_colvalid", col_valid, 0);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_col_valid", col_valid, 0);
    check_eq("rst_col_data", col_data, 0);
    check_eq("rst_col_idx", col_idx, 0);
    check_eq("rst_col_last", col_last, 0);
    check_eq("rst_col_owner", col_owner, 0);
    check_eq("rst_req_ready", req_ready, 0);
    reset = 1'b0;

    // Single request, latency and first address
    @(posedge clk); #1;
    req_valid = 2'b01; req_char = 16'h0041;
    wait_grant();
    check_eq("t1_ready", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check_eq("t1_addr_col0", rom_addr, 11'h208);
    check_eq("t1_valid_a1", col_valid, 0);
    @(negedge clk);
    check_eq("t1_valid_a2", col_valid, 0);
    @(negedge clk);
    check_eq("t1_valid_a3", col_valid, 1);
    drain();

    // Round-robin alternation from reset
    do_reset();
    grant_log.delete();
    @(posedge clk); #1;
    req_valid = 2'b11; req_char = 16'h3130;
    for (int i = 0; i < 200 && grant_log.size() < 4; i++) @(negedge clk);
    drain();
    for (int i = 0; i < 4; i++)
      check_eq("t2_order", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'd2, 32'(i % 2));

    // Backpressure: toggling ready, then a long stall
    @(posedge clk); #1;
    req_valid = 2'b11; req_char = 16'(($urandom));
    for (int i = 0; i < 40; i++) begin
      col_ready = i[0];
      @(posedge clk); #1;
    end
    col_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1 col_ready = 1'b1;
    drain();

    // Back-to-back glyphs from port 1: one bubble between glyphs
    bubble_en = 1'b1; n_bubble = 0;
    @(posedge clk); #1;
    req_valid = 2'b10; req_char = 16'h5A00;
    repeat (45) @(posedge clk);
    drain();
    bubble_en = 1'b0;
    check_eq("bubble_seen", n_bubble > 0, 1);

    // Reset mid-glyph, then char 0xFF
    @(posedge clk); #1;
    req_valid = 2'b01; req_char = 16'h0041;
    wait_grant();
    @(posedge clk); #1 req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rom_addr == 11'h20B) break;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("mr_col_valid", col_valid, 0);
    check_eq("mr_col_data", col_data, 0);
    check_eq("mr_col_idx", col_idx, 0);
    check_eq("mr_col_last", col_last, 0);
    check_eq("mr_col_owner", col_owner, 0);
    check_eq("mr_rom_addr", rom_addr, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 req_valid = 2'b01; req_char = 16'h00FF;
    wait_grant();
    @(posedge clk); #1 req_valid = '0;
    drain();
    check_eq("mr_pop_count", n_pop, 8);
    check_eq("mr_last_addr", rom_addr, 11'h7FF);

    // Reverse video on char 0x00 (inverted only when the feature is built)
    @(posedge clk); #1;
    req_valid = 2'b01; req_char = 16'h0000; req_inv = 2'b01;
    wait_grant();
    @(posedge clk); #1 req_valid = '0; req_inv = '0;
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom);
      req_char  = 16'($urandom);
      req_inv   = 2'($urandom);
      col_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/font_glyph_fetcher.md
Name: font_glyph_fetcher

Overview:
Sequencer and arbiter in front of the 8x8 CGA font ROM (2048 x 8, synchronous read, one-cycle latency, address = {char[7:0], col[2:0]}). Two requesters share the ROM: port 0 is display scan-out and port 1 is the CPU text console. The block accepts one character code per grant, issues the 8 column reads back-to-back, and streams the 8 column bytes out through a valid/ready interface with backpressure. It sits between the text buffer logic and the font ROM instance.

Parameters:
FIFO_DEPTH, 2, output column buffer entries; credit logic is sized for this value, minimum 2.
NREQ, 2, requester count; fixed at 2, with round-robin between port 0 and port 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-port glyph request
req_char  in  16  port i character code on [8i+7:8i]
req_ready  out  2  one-hot, one-cycle pulse; request accepted when req_valid[i] & req_ready[i]
rom_addr  out  11  font ROM address = {char, col}
rom_data  in  8  font ROM read data, valid the cycle after rom_addr
col_valid  out  1  column byte available
col_ready  in  1  consumer accepts the column
col_data  out  8  glyph column byte (bit 0 = top row)
col_idx  out  3  column number 0..7
col_last  out  1  col_idx == 7
col_owner  out  1  port that requested this glyph

Behaviour:
- Reset (async assert, sync deassert by the user):
  - state IDLE; FIFO empty; in-flight flag 0; rr pointer = 0, so port 0 wins the first tie.
  - req_ready=0, col_valid=0, col_data=0, col_idx=0, col_last=0, col_owner=0, rom_addr=0.
- FSM state IDLE:
  - If any req_valid is set, grant one. Single valid: that port. Both valid: the port != rr pointer's last grant (round-robin).
  - Pulse req_ready[g] for one cycle. Latch char and owner. Update the rr pointer. Go to FETCH with col=0.
  - No grant is made while in FETCH.
- FSM state FETCH:
  - Column col is issued (rom_addr={char,col}, in-flight set) in cycle N iff count + inflight − (col_valid & col_ready) < FIFO_DEPTH. Otherwise rom_addr holds and col does not advance.
  - After col 7 is issued, return to IDLE. Arbitration of the next glyph happens in the following cycle.
- Datapath timing:
  - rom_data in cycle N+1 is written to the FIFO at the end of N+1, tagged {col, owner}.
  - Column appears at the FIFO head, col_valid=1, in cycle N+2.
  - Latency: accept in cycle A → rom_addr col0 in A+1 → col_valid in A+3.
  - Steady-state throughput with col_ready=1: 1 column/cycle. There is 1 idle issue cycle between consecutive glyphs.
- Output handshake:
  - col_data, col_idx, col_last and col_owner are stable while col_valid & !col_ready.
  - col_valid never drops without a pop.
  - Columns of a glyph appear in order 0..7. Glyphs appear in grant order.
- Boundaries:
  - FIFO full with data returning: impossible by the credit rule; the bench asserts no overflow.
  - Pop and push in the same cycle on a full FIFO: allowed, count unchanged.
  - req_valid dropped before grant: allowed, nothing latched.
  - Reset mid-glyph: in-flight read and FIFO contents are discarded; no partial glyph is emitted after reset.
  - Character 0x00 and 0xFF: addresses 0x000..0x007 and 0x7F8..0x7FF, no wrap.

Optional Feature:
FONT_FETCH_INVERT_EN:
- Defined: an extra input req_inv [2] is latched with the grant. Columns of that glyph are emitted as ~rom_data (reverse video/cursor). The invert tag travels with the FIFO entry.
- Undefined: the port is absent and col_data equals rom_data.

Decomposition:
- Package font_fetch_pkg:
  - Constants GLYPH_COLS=8, CHAR_W=8, ROM_AW=11, COL_W=3.
  - FSM state enum {IDLE, FETCH}.
  - FIFO entry struct {data[7:0], col[2:0], owner, inv}.
- Sub-module font_col_fifo: FIFO_DEPTH-entry synchronous FIFO with count output, push/pop on the same cycle, async reset. The top level holds the FSM, arbiter and credit logic.

Test Plan:
- Single request, port 0, char 0x41, col_ready=1 → req_ready[0] pulse at A; col_valid A+3..A+10. col_data = ROM[0x208..0x20F], col_idx 0..7, col_last only on idx 7, col_owner=0.
- Both ports valid continuously (chars 0x30 and 0x31) → grants alternate 0,1,0,1 starting with port 0 after reset. Glyphs emerge in the same order with the matching col_owner.
- col_ready toggling 1010..., and col_ready=0 for 20 cycles mid-glyph → no lost or duplicated columns. Outputs are stable while stalled; FIFO count ≤ 2; 8 columns in order.
- Back-to-back glyphs from port 1 with col_ready=1 → exactly 1 bubble cycle between col_last and the next col_idx=0.
- Reset asserted in the cycle after column 3 is issued → all outputs 0 immediately. After release, the next request 0xFF yields ROM[0x7F8..0x7FF] with no stale columns.
- With FONT_FETCH_INVERT_EN, req_inv[0]=1 and char 0x00 → col_data = 0xFF ^ ROM[0x000..0x007]. Without the macro, the same stimulus yields ROM values unchanged.
